periph_leds_pwm: RTL and testbench
==================================

# periph_leds_pwm

Parametrised LED controller peripheral on the `PERIPH_*` register bus, driving `CHANNELS` LED outputs. Each channel is independently off, on, PWM-dimmed or blinking, with glitch-free duty updates. A shared prescaler and PWM counter set the timing for all channels. Sits beside the other `periph_*` devices on the CPU peripheral bus; its register 0–3 layout matches the standard peripheral header.

## Interface
- `DATA_WIDTH`, `` `PERIPH_DATA_WIDTH ``: bus data width, ≥16.
- `ADDR_WIDTH`, `` `PERIPH_ADDR_WIDTH ``: bus address width.
- `CHANNELS`, 8: number of LED outputs, 1..(2^ADDR_WIDTH − 4).
- `PWM_BITS`, 8: duty and PWM counter width, ≤ DATA_WIDTH−8.
- `DEVICE_TYPE`, 32'h0000_0002: value of register 0.
- `DEVICE_ID`, 32'h0001_0001: value of register 1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on `clk`.
- `addr` in ADDR_WIDTH: register index.
- `data` inout DATA_WIDTH: bidirectional bus; driven only during reads.
- `read` in 1: read request, held by the master until `ready`.
- `write` in 1: write request, held by the master until `ready`.
- `ready` out 1: one-cycle access acknowledge.
- `out` out CHANNELS: LED drive, active-high.

## Operation
- Register map:
  - 0: type (RO).
  - 1: id (RO).
  - 2: CONFIG.
    - bit DATA_WIDTH−1: `EN`.
    - [15:8]: `BLINK_DIV`.
    - [7:0]: `PRESC`.
  - 3: STATUS (RO).
    - bit 0: blink phase.
    - [8+PWM_BITS−1:8]: live `pwm_cnt`.
  - 4+i: CHi.
    - [PWM_BITS+1:PWM_BITS]: mode (00 off, 01 on, 10 PWM, 11 blink).
    - [PWM_BITS−1:0]: duty.
- Writes to RO registers or to unmapped addresses are ignored. Reads of unmapped addresses return 0. Both still get `ready`.
- Prescaler: `tick` pulses once every PRESC+1 cycles. PRESC=0 gives a tick every cycle.
- `pwm_cnt` increments on `tick` and wraps from 2^PWM_BITS−1 to 0; the wrap cycle raises `wrap`.
- Blink counter increments on `wrap`. When it equals `BLINK_DIV`, it clears and the blink phase toggles.
- Duty shadow: the written duty goes into `duty_pend`; `duty_act` loads from `duty_pend` only on `wrap`. Mode changes take effect immediately.
- Channel output:
  - off → 0.
  - on → 1.
  - PWM → `duty_act > pwm_cnt`. Duty 0 is always off; duty max gives 255/256 on.
  - blink → phase AND (`duty_act` ≠ 0).
- `EN`=0: prescaler, `pwm_cnt`, blink counter and phase are held at 0, and `out` is all 0. Registers stay writable.
- `read` and `write` both high: treated as a write; `data` is not driven.

## Timing
- Reset values: `ready`=0, `out`=0, `data`=Z, CONFIG=0, all CHi=0, all counters and phase 0.
- Access handshake:
  - Accepted at an edge where (`read`|`write`) && !`ready`.
  - `ready`=1 for exactly the next cycle, then 0 even if the request is still held.
  - A request held after `ready` starts a new access one cycle later.
- Write: the register updates at the accepting edge, so the new value is visible to logic in the cycle `ready` is high.
- Read: `data_r` is captured at the accepting edge. `data` = `data_r` whenever `read` && !`write`, and is valid while `ready`=1.
- `out` is registered: one cycle of latency from a counter or mode change.
- Duty written mid-period takes effect at the first PWM cycle after the next `wrap`.
- `rst_n` low mid-access: `ready` is cleared and the access is dropped; `data` goes Z the cycle after, unless `read` stays high.

## Structure
- Shared in `constants.v`: register offsets (`LEDS_REG_CONFIG`=2, `LEDS_REG_STATUS`=3, `LEDS_REG_CH0`=4), mode encodings (`LED_MODE_OFF/ON/PWM/BLINK`), and the `EN` bit position.
- Sub-module `periph_led_channel`: holds `duty_pend`/`duty_act`, the mode and the output compare. Instantiated CHANNELS times via `generate`. The top holds the bus logic, prescaler, PWM and blink counters.

## Test plan
- Reset, then read registers 0, 1, 2, 3 → DEVICE_TYPE, DEVICE_ID, 0, 0; each read gives a 1-cycle `ready`; `out`=0.
- CONFIG = EN|PRESC=0, CH0 = PWM duty 64 → `out[0]` high 64 of every 256 cycles after the first `wrap`.
- CH1 = on, then CONFIG.EN=0 → `out[1]`=0 and STATUS `pwm_cnt` frozen at 0; set EN=1 → `out[1]`=1 again after 1 cycle.
- CH2 duty 200 → 20 written mid-period at `pwm_cnt`=100 → high-time stays 200 until the wrap, then 20.
- BLINK_DIV=1, PRESC=0, CH3 blink duty 1 → `out[3]` toggles every 512 cycles; STATUS bit 0 tracks it.
- Write to address 2^ADDR_WIDTH−1 (unmapped) → `ready` pulses and no register changes; read → 0. `read` and `write` both high → write performed and `data` stays Z.

Source files
------------

// File: rtl/periph_leds_pwm_pkg.sv
// Shared register offsets, LED mode encodings and field positions for the
// periph_leds_pwm peripheral.
package periph_leds_pwm_pkg;

   localparam int LEDS_REG_TYPE   = 0;
   localparam int LEDS_REG_ID     = 1;
   localparam int LEDS_REG_CONFIG = 2;
   localparam int LEDS_REG_STATUS = 3;
   localparam int LEDS_REG_CH0    = 4;

   localparam int LEDS_CFG_PRESC_LSB = 0;
   localparam int LEDS_CFG_BLINK_LSB = 8;
   localparam int LEDS_STAT_CNT_LSB  = 8;

   typedef enum logic [1:0] {
      LED_MODE_OFF   = 2'b00,
      LED_MODE_ON    = 2'b01,
      LED_MODE_PWM   = 2'b10,
      LED_MODE_BLINK = 2'b11
   } led_mode_e;

   // EN sits in the top bit of CONFIG whatever the bus width is.
   function automatic int leds_en_bit(input int data_width);
      return data_width - 1;
   endfunction

endpackage

// File: rtl/periph_leds_pwm_if.sv
// Address and handshake half of the PERIPH_* register bus; the tri-state
// data lines stay a plain inout port on the device.
interface periph_leds_pwm_if #(
   parameter int ADDR_WIDTH = 4
) ();
   logic [ADDR_WIDTH-1:0] addr;
   logic                  read;
   logic                  write;
   logic                  ready;

   modport master (output addr, output read, output write, input ready);
   modport slave  (input addr, input read, input write, output ready);
endinterface

// File: rtl/periph_leds_pwm_channel.sv
// One LED channel: mode register, shadowed duty (pending/active) and the
// registered output compare against the shared PWM counter.
module periph_led_channel
   import periph_leds_pwm_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_i,
   input  led_mode_e           mode_i,
   input  logic [PWM_BITS-1:0] duty_i,
   input  logic                wrap_i,
   input  logic                en_i,
   input  logic                phase_i,
   input  logic [PWM_BITS-1:0] pwm_cnt_i,
   output led_mode_e           mode_o,
   output logic [PWM_BITS-1:0] duty_pend_o,
   output logic                out_o
);
   led_mode_e           mode_q;
   logic [PWM_BITS-1:0] duty_pend_q;
   logic [PWM_BITS-1:0] duty_act_q;
   logic                out_q;
   logic                out_d;

   always_comb begin
      out_d = 1'b0;
      if (!en_i) begin
         out_d = 1'b0;
      end else begin
         case (mode_q)
            LED_MODE_OFF:   out_d = 1'b0;
            LED_MODE_ON:    out_d = 1'b1;
            LED_MODE_PWM:   out_d = (duty_act_q > pwm_cnt_i);
            LED_MODE_BLINK: out_d = phase_i && (duty_act_q != {PWM_BITS{1'b0}});
            default:        out_d = 1'b0;
         endcase
      end
   end

   // Duty only moves to the active copy on a period boundary so a write never
   // produces a truncated or stretched pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q      <= LED_MODE_OFF;
         duty_pend_q <= {PWM_BITS{1'b0}};
         duty_act_q  <= {PWM_BITS{1'b0}};
         out_q       <= 1'b0;
      end else begin
         if (wr_i) begin
            mode_q      <= mode_i;
            duty_pend_q <= duty_i;
         end
         if (wrap_i) begin
            duty_act_q <= duty_pend_q;
         end
         out_q <= out_d;
      end
   end

   assign mode_o      = mode_q;
   assign duty_pend_o = duty_pend_q;
   assign out_o       = out_q;
endmodule

// File: rtl/periph_leds_pwm.sv
// LED controller peripheral: register bus front end, shared prescaler, PWM
// and blink counters, and CHANNELS instances of periph_led_channel.
module periph_leds_pwm
   import periph_leds_pwm_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter int          ADDR_WIDTH  = 4,
   parameter int          CHANNELS    = 8,
   parameter int          PWM_BITS    = 8,
   parameter logic [31:0] DEVICE_TYPE = 32'h0000_0002,
   parameter logic [31:0] DEVICE_ID   = 32'h0001_0001
) (
   input  logic                  clk,
   input  logic                  rst_n,
   periph_leds_pwm_if.slave      bus,
   inout  wire  [DATA_WIDTH-1:0] data,
   output logic [CHANNELS-1:0]   out
);
   localparam int EN_BIT = leds_en_bit(DATA_WIDTH);

   logic                  ready_q;
   logic [DATA_WIDTH-1:0] data_r_q;
   logic                  en_q;
   logic [7:0]            blink_div_q;
   logic [7:0]            presc_q;
   logic [7:0]            presc_cnt_q;
   logic [PWM_BITS-1:0]   pwm_cnt_q;
   logic [7:0]            blink_cnt_q;
   logic                  phase_q;

   logic [31:0]           addr_s;
   logic                  accept_s, wr_acc_s, rd_acc_s, tick_s, wrap_s;
   logic [DATA_WIDTH-1:0] rdata_s, cfg_word_s, status_word_s;
   logic [CHANNELS-1:0]   ch_wr_s;
   led_mode_e             ch_mode_s [CHANNELS];
   logic [PWM_BITS-1:0]   ch_duty_s [CHANNELS];
   logic                  unused_data_s;

   assign addr_s   = 32'(bus.addr);
   assign accept_s = (bus.read | bus.write) & ~ready_q;
   assign wr_acc_s = accept_s & bus.write;
   assign rd_acc_s = accept_s & bus.read & ~bus.write;
   assign tick_s   = en_q && (presc_cnt_q >= presc_q);
   assign wrap_s   = tick_s && (pwm_cnt_q == {PWM_BITS{1'b1}});
   assign unused_data_s = ^data;

   assign data     = (bus.read && !bus.write) ? data_r_q : {DATA_WIDTH{1'bz}};
   assign bus.ready = ready_q;

   always_comb begin
      cfg_word_s = {DATA_WIDTH{1'b0}};
      cfg_word_s[EN_BIT] = en_q;
      cfg_word_s[LEDS_CFG_BLINK_LSB +: 8] = blink_div_q;
      cfg_word_s[LEDS_CFG_PRESC_LSB +: 8] = presc_q;
      status_word_s = {DATA_WIDTH{1'b0}};
      status_word_s[0] = phase_q;
      status_word_s[LEDS_STAT_CNT_LSB +: PWM_BITS] = pwm_cnt_q;
   end

   always_comb begin
      rdata_s = {DATA_WIDTH{1'b0}};
      ch_wr_s = {CHANNELS{1'b0}};
      case (addr_s)
         32'(LEDS_REG_TYPE):   rdata_s = DATA_WIDTH'(DEVICE_TYPE);
         32'(LEDS_REG_ID):     rdata_s = DATA_WIDTH'(DEVICE_ID);
         32'(LEDS_REG_CONFIG): rdata_s = cfg_word_s;
         32'(LEDS_REG_STATUS): rdata_s = status_word_s;
         default: begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (addr_s == 32'(LEDS_REG_CH0 + i)) begin
                  rdata_s    = DATA_WIDTH'({ch_mode_s[i], ch_duty_s[i]});
                  ch_wr_s[i] = wr_acc_s;
               end else begin
                  ch_wr_s[i] = 1'b0;
               end
            end
         end
      endcase
   end

   // Bus handshake, read capture and CONFIG register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready_q     <= 1'b0;
         data_r_q    <= {DATA_WIDTH{1'b0}};
         en_q        <= 1'b0;
         blink_div_q <= 8'd0;
         presc_q     <= 8'd0;
      end else begin
         ready_q <= accept_s;
         if (rd_acc_s) begin
            data_r_q <= rdata_s;
         end
         if (wr_acc_s && (addr_s == 32'(LEDS_REG_CONFIG))) begin
            en_q        <= data[EN_BIT];
            blink_div_q <= data[LEDS_CFG_BLINK_LSB +: 8];
            presc_q     <= data[LEDS_CFG_PRESC_LSB +: 8];
         end
      end
   end

   // Timebase; >= on the prescaler keeps it from running away if PRESC shrinks.
   always_ff @(posedge clk) begin
      if (!rst_n || !en_q) begin
         presc_cnt_q <= 8'd0;
         pwm_cnt_q   <= {PWM_BITS{1'b0}};
         blink_cnt_q <= 8'd0;
         phase_q     <= 1'b0;
      end else begin
         presc_cnt_q <= tick_s ? 8'd0 : presc_cnt_q + 8'd1;
         if (tick_s) begin
            pwm_cnt_q <= pwm_cnt_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
         end
         if (wrap_s) begin
            if (blink_cnt_q == blink_div_q) begin
               blink_cnt_q <= 8'd0;
               phase_q     <= ~phase_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + 8'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      periph_led_channel #(
         .PWM_BITS (PWM_BITS)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .wr_i        (ch_wr_s[g]),
         .mode_i      (led_mode_e'(data[PWM_BITS +: 2])),
         .duty_i      (data[PWM_BITS-1:0]),
         .wrap_i      (wrap_s),
         .en_i        (en_q),
         .phase_i     (phase_q),
         .pwm_cnt_i   (pwm_cnt_q),
         .mode_o      (ch_mode_s[g]),
         .duty_pend_o (ch_duty_s[g]),
         .out_o       (out[g])
      );
   end
endmodule

// File: tb/tb_periph_leds_pwm.sv
// Directed, table-driven bench for periph_leds_pwm with hand-computed
// expectations and a few timed sequences for PWM, blink and enable behaviour.
module tb_periph_leds_pwm;
   logic        clk = 1'b0;
   logic        rst_n;
   wire  [31:0] data;
   logic [31:0] wdata;
   logic        drv;
   logic [7:0]  out;

   periph_leds_pwm_if #(.ADDR_WIDTH(4)) bus ();

   assign data = drv ? wdata : 32'hzzzz_zzzz;

   periph_leds_pwm #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (4),
      .CHANNELS   (8),
      .PWM_BITS   (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .data  (data),
      .out   (out)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic bus_xfer(input logic do_rd, input logic do_wr, input logic [3:0] a,
                           input logic [31:0] wd, output logic [31:0] rd);
      int n;
      @(negedge clk);
      bus.addr = a; bus.read = do_rd; bus.write = do_wr; drv = do_wr; wdata = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.ready && n < 8);
      check("ready_high", 32'(bus.ready), 32'd1);
      rd = data;
      bus.read = 1'b0; bus.write = 1'b0; drv = 1'b0;
      @(negedge clk);
      check("ready_one_cycle", 32'(bus.ready), 32'd0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] wd);
      logic [31:0] dummy;
      bus_xfer(1'b0, 1'b1, a, wd, dummy);
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] v);
      bus_xfer(1'b1, 1'b0, a, 32'd0, v);
   endtask

   task automatic wait_level(input int ch, input logic lvl, input int bound, output int n);
      n = 0;
      while (out[ch] !== lvl && n < bound) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_len(input int ch, input logic lvl, input int bound, output int n);
      n = 0;
      while (out[ch] === lvl && n < bound) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] v;
      int n, h1, h2, lo;

      rst_n = 1'b0; bus.addr = 4'd0; bus.read = 1'b0; bus.write = 1'b0;
      drv = 1'b0; wdata = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_ready", 32'(bus.ready), 32'd0);
      check("reset_out", 32'(out), 32'd0);
      rst_n = 1'b1;

      vecs.push_back('{1'b0, 4'd0,  32'd0,          32'h0000_0002, "rd_type"});
      vecs.push_back('{1'b0, 4'd1,  32'd0,          32'h0001_0001, "rd_id"});
      vecs.push_back('{1'b0, 4'd2,  32'd0,          32'h0000_0000, "rd_config_rst"});
      vecs.push_back('{1'b0, 4'd3,  32'd0,          32'h0000_0000, "rd_status_rst"});
      vecs.push_back('{1'b0, 4'd4,  32'd0,          32'h0000_0000, "rd_ch0_rst"});
      vecs.push_back('{1'b1, 4'd5,  32'h0000_0233,  32'd0,         "wr_ch1"});
      vecs.push_back('{1'b0, 4'd5,  32'd0,          32'h0000_0233, "rd_ch1"});
      vecs.push_back('{1'b1, 4'd2,  32'h7FFF_1234,  32'd0,         "wr_config_mask"});
      vecs.push_back('{1'b0, 4'd2,  32'd0,          32'h0000_1234, "rd_config_mask"});
      vecs.push_back('{1'b1, 4'd6,  32'hFFFF_F3AB,  32'd0,         "wr_ch2_mask"});
      vecs.push_back('{1'b0, 4'd6,  32'd0,          32'h0000_03AB, "rd_ch2_mask"});
      vecs.push_back('{1'b1, 4'd15, 32'hFFFF_FFFF,  32'd0,         "wr_unmapped"});
      vecs.push_back('{1'b0, 4'd15, 32'd0,          32'h0000_0000, "rd_unmapped"});
      vecs.push_back('{1'b1, 4'd0,  32'h1234_5678,  32'd0,         "wr_type_ro"});
      vecs.push_back('{1'b0, 4'd0,  32'd0,          32'h0000_0002, "rd_type_ro"});
      vecs.push_back('{1'b1, 4'd3,  32'hFFFF_FFFF,  32'd0,         "wr_status_ro"});
      vecs.push_back('{1'b0, 4'd3,  32'd0,          32'h0000_0000, "rd_status_ro"});
      vecs.push_back('{1'b1, 4'd2,  32'h0000_0000,  32'd0,         "wr_config_clr"});
      vecs.push_back('{1'b0, 4'd2,  32'd0,          32'h0000_0000, "rd_config_clr"});
      vecs.push_back('{1'b1, 4'd5,  32'h0000_0000,  32'd0,         "wr_ch1_clr"});
      vecs.push_back('{1'b1, 4'd6,  32'h0000_0000,  32'd0,         "wr_ch2_clr"});

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            wr(vecs[i].addr, vecs[i].wd);
         end else begin
            rd(vecs[i].addr, v);
            check(vecs[i].name, v, vecs[i].exp);
         end
      end
      check("out_idle", 32'(out), 32'd0);

      // CH0 PWM duty 64 at PRESC=0: first wrap 256 cycles after enable.
      wr(4'd4, 32'h0000_0240);
      wr(4'd2, 32'h8000_0000);
      wait_level(0, 1'b1, 400, n);
      check("pwm64_first_wrap_delay", 32'(n), 32'd256);
      run_len(0, 1'b1, 400, n);
      check("pwm64_high", 32'(n), 32'd64);
      run_len(0, 1'b0, 400, n);
      check("pwm64_low", 32'(n), 32'd192);

      // Enable gating with CH1 forced on.
      wr(4'd5, 32'h0000_0100);
      check("ch1_on", 32'(out[1]), 32'd1);
      wr(4'd2, 32'h0000_0000);
      check("en0_out", 32'(out), 32'd0);
      repeat (5) @(negedge clk);
      rd(4'd3, v);
      check("en0_status_a", v, 32'd0);
      repeat (7) @(negedge clk);
      rd(4'd3, v);
      check("en0_status_b", v, 32'd0);
      check("en0_out_held", 32'(out), 32'd0);
      wr(4'd2, 32'h8000_0000);
      check("en1_ch1_on", 32'(out[1]), 32'd1);
      wr(4'd5, 32'h0000_0000);

      // CH2 duty 200, rewritten to 20 mid-period.
      wr(4'd6, 32'h0000_02C8);
      wait_level(2, 1'b1, 600, n);
      check("ch2_rise_seen", 32'(n < 600), 32'd1);
      fork
         begin
            run_len(2, 1'b1, 400, h1);
            run_len(2, 1'b0, 400, lo);
            run_len(2, 1'b1, 400, h2);
         end
         begin
            repeat (97) @(negedge clk);
            wr(4'd6, 32'h0000_0214);
         end
      join
      check("ch2_high_before_wrap", 32'(h1), 32'd200);
      check("ch2_high_after_wrap", 32'(h2), 32'd20);

      // CH3 blink, BLINK_DIV=1: 512-cycle phases.
      wr(4'd2, 32'h0000_0000);
      wr(4'd7, 32'h0000_0301);
      wr(4'd2, 32'h8000_0100);
      wait_level(3, 1'b1, 1500, n);
      check("blink_rise_seen", 32'(n < 1500), 32'd1);
      run_len(3, 1'b1, 1200, n);
      check("blink_high", 32'(n), 32'd512);
      run_len(3, 1'b0, 1200, n);
      check("blink_low", 32'(n), 32'd512);
      rd(4'd3, v);
      check("status_phase_high", 32'(v[0]), 32'd1);
      wait_level(3, 1'b0, 1200, n);
      rd(4'd3, v);
      check("status_phase_low", 32'(v[0]), 32'd0);

      // read+write together: the write wins and the DUT keeps off the bus.
      rd(4'd1, v);
      bus_xfer(1'b1, 1'b1, 4'd8, 32'h0000_0155, v);
      rd(4'd8, v);
      check("rw_both_write", v, 32'h0000_0155);
      check("rw_both_ch4_on", 32'(out[4]), 32'd1);

      // Reset while an access is being acknowledged.
      @(negedge clk);
      bus.addr = 4'd1; bus.read = 1'b1;
      @(negedge clk);
      rst_n = 1'b0; bus.read = 1'b0;
      @(negedge clk);
      check("rst_mid_ready", 32'(bus.ready), 32'd0);
      check("rst_mid_out", 32'(out), 32'd0);
      rst_n = 1'b1;
      rd(4'd2, v);
      check("rst_mid_config", v, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
